irq_prio_ctrl: RTL
==================

Name: irq_prio_ctrl

Overview:
- Parametrised interrupt controller for the five-stage pipeline. Generalises the fixed three-line ir1/ir2/ir3 scheme to NUM_IRQ channels.
- Detects request edges and holds them in a pending latch. Applies a per-channel mask and a global enable, and selects the highest-priority eligible channel.
- Supports nested interrupts through an in-service register: a request preempts only if it outranks every channel currently in service.
- Drives the interrupt request, channel id and vector address to the IF/CP0 logic. Retires one in-service level on each ERET.

Parameters:
NUM_IRQ, 4, number of request channels (2..16); a higher index means a higher priority.
VEC_BASE, 32'h0000_0800, vector address of channel 0.
VEC_STRIDE, 32'h0000_0040, vector address spacing between channels.
DEPTH_W, 5, width of nest_depth; must satisfy 2^DEPTH_W > NUM_IRQ.

Ports:
clk  input  1  system clock; the only clock.
CLR  input  1  synchronous active-high reset.
en  input  1  pipeline-advance enable (low while halted or paused).
ir_in  input  NUM_IRQ  request lines, already synchronous to clk.
int_ack  input  1  pipeline has taken the presented interrupt.
eret  input  1  ERET retiring, qualified by en.
mask_we  input  1  write strobe for the mask register.
mask_wdata  input  NUM_IRQ  new mask value (1 = channel enabled).
gie_we  input  1  write strobe for the global enable.
gie_wdata  input  1  new global enable value.
int_req  output  1  an eligible interrupt is presented.
int_id  output  $clog2(NUM_IRQ)  id of the presented channel.
int_vec  output  32  handler address, VEC_BASE + int_id*VEC_STRIDE.
pending  output  NUM_IRQ  pending latch, for LED display.
in_service  output  NUM_IRQ  in-service register.
nest_depth  output  DEPTH_W  count of set in_service bits.

Behaviour:
- Reset (CLR high at a clk edge):
  - pending, in_service and nest_depth are cleared to 0; mask is set to all ones; gie is set to 1.
  - ir_prev is loaded with ir_in, so a line held high through reset does not fire.
  - CLR takes priority over every other input.
- Edge detect: rise = ir_in & ~ir_prev. ir_prev <= ir_in every cycle, independent of en.
- Pending latch:
  - pending[i] is set at the edge where rise[i] is seen, independent of en and mask.
  - pending[i] is cleared only by an accepted ack of channel i.
  - If a set and a clear of the same channel land in one cycle, the set wins.
- Threshold: lvl = index of the highest set in_service bit + 1, or 0 when in_service is empty.
- Eligibility: elig[i] = pending[i] & mask[i] & (i >= lvl).
- Outputs (combinational from registered state):
  - int_req = gie & |elig.
  - int_id = index of the highest set elig bit; 0 when int_req is low.
  - int_vec is computed from int_id.
- Latency: a rise sampled at edge k gives int_req high in cycle k+1, provided the channel is eligible.
- Accept: occurs at an edge where int_ack & int_req & en.
  - pending[int_id] is cleared and in_service[int_id] is set.
  - nest_depth is incremented.
  - int_ack without int_req, or with en low, is ignored.
- ERET: at an edge where eret & en, the highest set in_service bit is cleared and nest_depth is decremented. If in_service is empty there is no effect and no underflow.
- Accept and ERET in the same cycle:
  - in_service_next = (in_service & ~top) | onehot(int_id).
  - Eligibility uses pre-edge state.
  - nest_depth is unchanged.
- Masking: a masked channel stays pending and is presented once it is unmasked (one cycle after the mask_we edge).
- gie low holds int_req low; pending and in_service are kept.
- Config writes take effect at the edge regardless of en. Each write has its own strobe (mask_we, gie_we), and both may be written in the same cycle.
- With en low: accept and ERET are frozen; edge capture and config writes continue.
- Equal-priority or lower-priority requests during service stay pending until ERET drops lvl.

Test Plan:
- NUM_IRQ=4, reset with ir_in=4'b0100 held → pending=0, int_req=0. Release and re-raise bit 2 → pending=4'b0100, int_req=1 next cycle, int_id=2, int_vec=0x880.
- Pulse ir_in bits 1 and 3 in the same cycle → int_id=3. Ack → in_service=4'b1000, pending=4'b0010, int_req=0 (bit 1 is below the threshold).
- With in_service=4'b0010, raise bit 3 → int_req=1, id=3. Ack → nest_depth=2. ERET → in_service=4'b0010. ERET → in_service=0, and pending bit 0 is presented if it is set.
- mask_wdata=4'b1101 while bit 1 is pending → int_req=0. Rewrite mask to 4'b1111 → int_req=1, id=1.
- With en=0, ack and eret are asserted → no state change, while a rise is still captured into pending. Ack, eret and a new rise of the same channel in one cycle → merge rule holds and the re-rise stays pending.
- ERET with in_service=0 → nest_depth remains 0. gie_wdata=0 → int_req=0 with pending intact.

Source files
------------

// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: NUM_IRQ-channel nested interrupt controller.
// Requests are edge-detected into a pending latch. A channel is eligible when it is
// pending, unmasked and strictly above the highest channel in service. The highest
// eligible channel is presented with its vector address. ERET retires one level.
module irq_prio_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0040,
  parameter int          DEPTH_W    = 5
) (
  input  logic                       clk,
  input  logic                       CLR,
  input  logic                       en,
  input  logic [NUM_IRQ-1:0]         ir_in,
  input  logic                       int_ack,
  input  logic                       eret,
  input  logic                       mask_we,
  input  logic [NUM_IRQ-1:0]         mask_wdata,
  input  logic                       gie_we,
  input  logic                       gie_wdata,
  output logic                       int_req,
  output logic [$clog2(NUM_IRQ)-1:0] int_id,
  output logic [31:0]                int_vec,
  output logic [NUM_IRQ-1:0]         pending,
  output logic [NUM_IRQ-1:0]         in_service,
  output logic [DEPTH_W-1:0]         nest_depth
);

  localparam int ID_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] ir_prev;
  logic [NUM_IRQ-1:0] mask;
  logic               gie;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] top_oh;
  logic [NUM_IRQ-1:0] acc_oh;
  logic [ID_W-1:0]    top_idx;
  logic [ID_W-1:0]    sel_idx;
  logic               have_is;
  logic               accept;
  logic               retire;

  // Threshold, eligibility and highest-eligible selection from registered state
  always_comb begin
    rise    = ir_in & ~ir_prev;
    top_oh  = '0;
    top_idx = '0;
    have_is = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (in_service[i]) begin
        top_oh    = '0;
        top_oh[i] = 1'b1;
        top_idx   = ID_W'(i);
        have_is   = 1'b1;
      end
    end
    elig    = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      elig[i] = pending[i] & mask[i] & (~have_is | (ID_W'(i) > top_idx));
      if (elig[i]) begin
        sel_idx = ID_W'(i);
      end
    end
  end

  // Presented request, channel id and handler address
  always_comb begin
    int_req = gie & (|elig);
    int_id  = int_req ? sel_idx : '0;
    int_vec = VEC_BASE + VEC_STRIDE * 32'(int_id);
  end

  // Accept and retire qualifiers plus the one-hot of the accepted channel
  always_comb begin
    accept = int_ack & int_req & en;
    retire = eret & en & have_is;
    acc_oh = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      acc_oh[i] = accept & (int_id == ID_W'(i));
    end
  end

  // State update: edge capture, pending latch, in-service stack, config registers
  always_ff @(posedge clk) begin
    if (CLR) begin
      ir_prev    <= ir_in;
      pending    <= '0;
      in_service <= '0;
      nest_depth <= '0;
      mask       <= '1;
      gie        <= 1'b1;
    end else begin
      ir_prev <= ir_in;
      // rise is ORed last so a same-cycle set beats the accept clear
      pending    <= (pending & ~acc_oh) | rise;
      in_service <= (in_service & ~(retire ? top_oh : '0)) | acc_oh;
      case ({accept, retire})
        2'b10:   nest_depth <= nest_depth + DEPTH_W'(1);
        2'b01:   nest_depth <= nest_depth - DEPTH_W'(1);
        default: nest_depth <= nest_depth;
      endcase
      if (mask_we) begin
        mask <= mask_wdata;
      end
      if (gie_we) begin
        gie <= gie_wdata;
      end
    end
  end

endmodule
